// File: rtl/generic_stream_upsizer_if.sv
// Stream bundle between a narrow FIFO pop side and a wide-bus master, as seen
// through the upsizer: slave = the upsizer itself, master = whoever drives it.
interface generic_stream_upsizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
);
  localparam int CNT_W = $clog2(RATIO + 1);

  logic                        clear_i;
  logic [DATA_WIDTH-1:0]       data_i;
  logic                        valid_i;
  logic                        last_i;
  logic                        grant_o;
  logic [DATA_WIDTH*RATIO-1:0] data_o;
  logic [CNT_W-1:0]            cnt_o;
  logic                        valid_o;
  logic                        grant_i;

  modport slave (
    input  clear_i, data_i, valid_i, last_i, grant_i,
    output grant_o, data_o, cnt_o, valid_o
  );

  modport master (
    output clear_i, data_i, valid_i, last_i, grant_i,
    input  grant_o, data_o, cnt_o, valid_o
  );
endinterface

// File: rtl/generic_stream_upsizer.sv
// Packs up to RATIO narrow words (lane 0 first) into one wide word; last_i closes
// a word early. One narrow word per cycle, including the cycle a wide word leaves.
module generic_stream_upsizer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RATIO      = 4,
  localparam int CNT_W      = $clog2(RATIO + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  generic_stream_upsizer_if.slave  bus
);

  if (RATIO < 1) begin : g_bad_ratio
    $error("generic_stream_upsizer: RATIO must be >= 1");
  end

  typedef enum logic {FILL, HOLD} state_e;

  state_e                 cs, ns;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  lane_q [RATIO];
  logic                   lane_we;
  logic [CNT_W-1:0]       lane_sel;
  logic                   grant;
  logic                   acc;
  logic                   pop;
  logic [CNT_W-1:0]       cnt_out;
  logic [DATA_WIDTH*RATIO-1:0] data_out;

  // grant never looks at valid_i so the FIFO side cannot form a combinational loop.
  assign grant = (cs == FILL) | bus.grant_i;
  assign acc   = bus.valid_i & grant;
  assign pop   = (cs == HOLD) & bus.grant_i;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    ns       = cs;
    cnt_d    = cnt_q;
    lane_we  = 1'b0;
    lane_sel = cnt_q;
    unique case (cs)
      FILL: begin
        if (acc) begin
          lane_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1) == CNT_W'(RATIO)) || bus.last_i) ns = HOLD;
        end
      end
      HOLD: begin
        if (pop) begin
          if (acc) begin
            // Hand-off cycle: the new word starts in lane 0 with no bubble.
            lane_we  = 1'b1;
            lane_sel = '0;
            cnt_d    = CNT_W'(1);
            ns       = ((RATIO == 1) || bus.last_i) ? HOLD : FILL;
          end else begin
            cnt_d = '0;
            ns    = FILL;
          end
        end
      end
      default: ns = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs    <= FILL;
      cnt_q <= '0;
    end else if (bus.clear_i) begin
      cs    <= FILL;
      cnt_q <= '0;
    end else begin
      cs    <= ns;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the lane registers are reset and cleared on purpose, so a word that
  // leaves right after reset or flush can never carry old payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RATIO; k++) lane_q[k] <= '0;
    end else if (bus.clear_i) begin
      for (int k = 0; k < RATIO; k++) lane_q[k] <= '0;
    end else begin
      for (int k = 0; k < RATIO; k++) begin
        if (lane_we && (lane_sel == CNT_W'(k))) lane_q[k] <= bus.data_i;
      end
    end
  end

  assign cnt_out = (cs == HOLD) ? cnt_q : '0;

  // Lanes at or above the count are forced to zero so leftovers of a longer
  // previous word never show through a short one.
  always_comb begin
    data_out = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) < cnt_out) data_out[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
    end
  end

  assign bus.grant_o = grant;
  assign bus.valid_o = (cs == HOLD);
  assign bus.cnt_o   = cnt_out;
  assign bus.data_o  = data_out;

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ((cs == HOLD) && !bus.grant_i && !bus.clear_i) |=> ($stable(data_out) && $stable(cnt_out)))
    else $error("upsizer: pending wide word changed while stalled");

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_out <= CNT_W'(RATIO))
    else $error("upsizer: cnt_o above RATIO");

  a_no_write_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    !((cs == HOLD) && !bus.grant_i && lane_we))
    else $error("upsizer: lane written while stalled");
`endif

endmodule

// File: tb/tb_generic_stream_upsizer.sv
// Directed bench: DW=8 with RATIO=4 for the main checks and a RATIO=1 instance
// for the pass-through register stage.
module tb_generic_stream_upsizer;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  generic_stream_upsizer_if #(.DATA_WIDTH(8), .RATIO(4)) bus4 ();
  generic_stream_upsizer_if #(.DATA_WIDTH(8), .RATIO(1)) bus1 ();

  generic_stream_upsizer #(.DATA_WIDTH(8), .RATIO(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  generic_stream_upsizer #(.DATA_WIDTH(8), .RATIO(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push4(input logic [7:0] d, input logic l);
    bus4.valid_i = 1'b1;
    bus4.data_i  = d;
    bus4.last_i  = l;
    cyc();
  endtask

  task automatic idle4();
    bus4.valid_i = 1'b0;
    bus4.last_i  = 1'b0;
    settle();
  endtask

  initial begin
    logic [31:0] exp_word;
    int j;

    rst_n        = 1'b0;
    bus4.clear_i = 1'b0; bus4.data_i = '0; bus4.valid_i = 1'b0; bus4.last_i = 1'b0; bus4.grant_i = 1'b0;
    bus1.clear_i = 1'b0; bus1.data_i = '0; bus1.valid_i = 1'b0; bus1.last_i = 1'b0; bus1.grant_i = 1'b1;
    cyc();
    cyc();
    check("rst_valid", bus4.valid_o, 0);
    check("rst_cnt",   bus4.cnt_o,   0);
    check("rst_data",  bus4.data_o,  0);
    check("rst_grant", bus4.grant_o, 1);
    rst_n = 1'b1;
    cyc();

    // 1: full word, grant_i=1
    bus4.grant_i = 1'b1;
    push4(8'h11, 0); push4(8'h22, 0); push4(8'h33, 0);
    settle();
    check("t1_not_yet", bus4.valid_o, 0);
    push4(8'h44, 0);
    idle4();
    check("t1_valid", bus4.valid_o, 1);
    check("t1_data",  bus4.data_o,  32'h44332211);
    check("t1_cnt",   bus4.cnt_o,   4);
    cyc();
    check("t1_popped_valid", bus4.valid_o, 0);
    check("t1_popped_cnt",   bus4.cnt_o,   0);
    check("t1_popped_data",  bus4.data_o,  0);

    // 2: early close with last_i, upper lanes masked
    push4(8'hA1, 0);
    push4(8'hA2, 1);
    idle4();
    check("t2_valid", bus4.valid_o, 1);
    check("t2_data",  bus4.data_o,  32'h0000A2A1);
    check("t2_cnt",   bus4.cnt_o,   2);

    // 3: back-pressure in HOLD, then pop and accept in the same cycle
    bus4.grant_i = 1'b0;
    bus4.valid_i = 1'b1;
    bus4.data_i  = 8'hB1;
    settle();
    check("t3_grant_low", bus4.grant_o, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t3_hold_data",  bus4.data_o,  32'h0000A2A1);
      check("t3_hold_valid", bus4.valid_o, 1);
      check("t3_hold_cnt",   bus4.cnt_o,   2);
    end
    bus4.grant_i = 1'b1;
    settle();
    check("t3_grant_high", bus4.grant_o, 1);
    cyc();
    check("t3_after_pop_valid", bus4.valid_o, 0);
    push4(8'hB2, 0); push4(8'hB3, 0); push4(8'hB4, 0);
    idle4();
    check("t3_data", bus4.data_o, 32'hB4B3B2B1);
    check("t3_cnt",  bus4.cnt_o,  4);
    cyc();

    // 4: twelve back-to-back words, no bubbles
    for (int i = 0; i < 12; i++) begin
      bus4.valid_i = 1'b1;
      bus4.last_i  = 1'b0;
      bus4.data_i  = 8'(i + 1);
      settle();
      check("t4_grant", bus4.grant_o, 1);
      if (i > 0) begin
        j = i - 1;
        check("t4_valid", bus4.valid_o, ((j % 4) == 3) ? 1 : 0);
        if ((j % 4) == 3) begin
          exp_word = {8'(j + 1), 8'(j), 8'(j - 1), 8'(j - 2)};
          check("t4_data", bus4.data_o, exp_word);
        end
      end
      cyc();
    end
    idle4();
    check("t4_last_valid", bus4.valid_o, 1);
    check("t4_last_data",  bus4.data_o,  32'h0C0B0A09);
    cyc();

    // 5: flush mid-fill (with a lost accept) and flush in HOLD; last_i ignored without valid_i
    push4(8'hC1, 0);
    bus4.valid_i = 1'b0;
    bus4.last_i  = 1'b1;
    cyc();
    check("t5_last_ignored", bus4.valid_o, 0);
    push4(8'hC2, 0);
    bus4.clear_i = 1'b1;
    bus4.valid_i = 1'b1;
    bus4.data_i  = 8'hC3;
    settle();
    check("t5_grant_during_clear", bus4.grant_o, 1);
    cyc();
    bus4.clear_i = 1'b0;
    push4(8'hD1, 0); push4(8'hD2, 0); push4(8'hD3, 0); push4(8'hD4, 0);
    idle4();
    check("t5_valid", bus4.valid_o, 1);
    check("t5_data",  bus4.data_o,  32'hD4D3D2D1);
    check("t5_cnt",   bus4.cnt_o,   4);
    bus4.grant_i = 1'b0;
    bus4.clear_i = 1'b1;
    settle();
    check("t5_hold_before_clear", bus4.valid_o, 1);
    cyc();
    bus4.clear_i = 1'b0;
    settle();
    check("t5_cleared_valid", bus4.valid_o, 0);
    check("t5_cleared_data",  bus4.data_o,  0);
    check("t5_cleared_cnt",   bus4.cnt_o,   0);
    bus4.grant_i = 1'b1;

    // 6: async reset mid-fill and mid-HOLD
    push4(8'hE1, 0); push4(8'hE2, 0);
    idle4();
    rst_n = 1'b0;
    settle();
    check("t6_fill_rst_valid", bus4.valid_o, 0);
    check("t6_fill_rst_cnt",   bus4.cnt_o,   0);
    check("t6_fill_rst_data",  bus4.data_o,  0);
    cyc();
    rst_n = 1'b1;
    cyc();
    push4(8'hE1, 0); push4(8'hE2, 0); push4(8'hE3, 0); push4(8'hE4, 0);
    idle4();
    check("t6_hold_data", bus4.data_o, 32'hE4E3E2E1);
    rst_n = 1'b0;
    settle();
    check("t6_hold_rst_valid", bus4.valid_o, 0);
    check("t6_hold_rst_cnt",   bus4.cnt_o,   0);
    check("t6_hold_rst_data",  bus4.data_o,  0);
    cyc();
    rst_n = 1'b1;
    cyc();
    push4(8'hF1, 1);
    idle4();
    check("t6_single_data", bus4.data_o, 32'h000000F1);
    check("t6_single_cnt",  bus4.cnt_o,  1);
    cyc();

    // RATIO=1: one-cycle register stage
    bus1.valid_i = 1'b1;
    bus1.data_i  = 8'h5A;
    settle();
    check("r1_grant", bus1.grant_o, 1);
    check("r1_idle_valid", bus1.valid_o, 0);
    cyc();
    bus1.data_i = 8'h5B;
    settle();
    check("r1_valid", bus1.valid_o, 1);
    check("r1_data",  bus1.data_o,  8'h5A);
    check("r1_cnt",   bus1.cnt_o,   1);
    cyc();
    check("r1_data2", bus1.data_o, 8'h5B);
    bus1.grant_i = 1'b0;
    bus1.data_i  = 8'h5C;
    settle();
    check("r1_grant_low", bus1.grant_o, 0);
    cyc();
    check("r1_stall_data", bus1.data_o, 8'h5B);
    bus1.valid_i = 1'b0;
    bus1.grant_i = 1'b1;
    cyc();
    check("r1_drained", bus1.valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
